// File: rtl/alu_instr_sequencer_if.sv
// Control bus between the ALU instruction sequencer and its datapath.
// The instr_cnt signal exists only when ALU_SEQ_CYCLE_CNT_EN is defined.
interface alu_instr_sequencer_if #(
  parameter int WORD_W   = 32,
  parameter int NUM_REGS = 16
);
  logic                start;
  logic [WORD_W-1:0]   ir;
  logic                busy;
  logic                done;
  logic                illegal;
  logic [NUM_REGS-1:0] rin;
  logic [NUM_REGS-1:0] rout;
  logic [13:0]         alu_ctl;
  logic PCout, PCin, MARin, Read, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout, HIin, LOin;
`ifdef ALU_SEQ_CYCLE_CNT_EN
  logic [31:0]         instr_cnt;
`endif

  // master: the side issuing instructions and observing the strobes
  modport master (
    output start, ir,
    input
`ifdef ALU_SEQ_CYCLE_CNT_EN
      instr_cnt,
`endif
      busy, done, illegal, rin, rout, alu_ctl,
      PCout, PCin, MARin, Read, MDRin, MDRout, IRin,
      Yin, Zin, Zlowout, Zhighout, HIin, LOin
  );

  // slave: the sequencer itself
  modport slave (
    input start, ir,
    output
`ifdef ALU_SEQ_CYCLE_CNT_EN
      instr_cnt,
`endif
      busy, done, illegal, rin, rout, alu_ctl,
      PCout, PCin, MARin, Read, MDRin, MDRout, IRin,
      Yin, Zin, Zlowout, Zhighout, HIin, LOin
  );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Moore FSM sequencing fetch/decode/execute strobes for register-register ALU instructions.
// Optional retired-instruction counter enabled by defining ALU_SEQ_CYCLE_CNT_EN.
module alu_instr_sequencer #(
  parameter int WORD_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4
) (
  input logic                  clock,
  input logic                  clear,
  alu_instr_sequencer_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_T5   = 3'd6;
  localparam logic [2:0] S_T6   = 3'd7;

  logic [2:0] state_reg, state_next;

  logic [WORD_W-1:0]    ir_word;
  logic [4:0]           opcode;
  logic [REG_IDX_W-1:0] ra_idx, rb_idx, rc_idx;
  logic                 unused_ir_bits;

  assign ir_word        = bus.ir;
  assign opcode         = ir_word[31:27];
  assign ra_idx         = ir_word[26 -: REG_IDX_W];
  assign rb_idx         = ir_word[22 -: REG_IDX_W];
  assign rc_idx         = ir_word[18 -: REG_IDX_W];
  assign unused_ir_bits = ^ir_word[14:0];

  logic is_two_op, is_unary, is_muldiv;
  assign is_two_op = (opcode <= 5'd8);
  assign is_unary  = (opcode == 5'd11) || (opcode == 5'd12);
  assign is_muldiv = (opcode == 5'd9) || (opcode == 5'd10);

  // Opcode numbering differs from the alu_ctl bit order (shifts/rotates are permuted)
  logic [13:0] op_sel;
  always_comb begin
    op_sel = '0;
    case (opcode)
      5'd0:    op_sel[0]  = 1'b1;
      5'd1:    op_sel[1]  = 1'b1;
      5'd2:    op_sel[2]  = 1'b1;
      5'd3:    op_sel[3]  = 1'b1;
      5'd4:    op_sel[7]  = 1'b1;
      5'd5:    op_sel[8]  = 1'b1;
      5'd6:    op_sel[4]  = 1'b1;
      5'd7:    op_sel[5]  = 1'b1;
      5'd8:    op_sel[6]  = 1'b1;
      5'd9:    op_sel[11] = 1'b1;
      5'd10:   op_sel[12] = 1'b1;
      5'd11:   op_sel[9]  = 1'b1;
      5'd12:   op_sel[10] = 1'b1;
      default: op_sel     = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.start) state_next = S_T0;
      S_T0:    state_next = S_T1;
      S_T1:    state_next = S_T2;
      S_T2:    state_next = S_T3;
      S_T3:    state_next = (is_two_op || is_muldiv || is_unary) ? S_T4 : S_IDLE;
      S_T4:    state_next = (is_two_op || is_muldiv) ? S_T5 : S_IDLE;
      S_T5:    state_next = is_muldiv ? S_T6 : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  logic busy, done, illegal, rin_en, rout_b_en, rout_c_en;
  logic [13:0] alu_sel;
  logic pc_out, pc_in, mar_in, mem_read, mdr_in, mdr_out, ir_in;
  logic y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;

  // Later T-states re-check the opcode class so done always pulses even if ir changes
  always_comb begin
    busy = 1'b0; done = 1'b0; illegal = 1'b0;
    rin_en = 1'b0; rout_b_en = 1'b0; rout_c_en = 1'b0; alu_sel = '0;
    pc_out = 1'b0; pc_in = 1'b0; mar_in = 1'b0; mem_read = 1'b0;
    mdr_in = 1'b0; mdr_out = 1'b0; ir_in = 1'b0; y_in = 1'b0; z_in = 1'b0;
    zlow_out = 1'b0; zhigh_out = 1'b0; hi_in = 1'b0; lo_in = 1'b0;
    case (state_reg)
      S_T0: begin
        busy = 1'b1; pc_out = 1'b1; mar_in = 1'b1; alu_sel[13] = 1'b1; z_in = 1'b1;
      end
      S_T1: begin
        busy = 1'b1; zlow_out = 1'b1; pc_in = 1'b1; mem_read = 1'b1; mdr_in = 1'b1;
      end
      S_T2: begin
        busy = 1'b1; mdr_out = 1'b1; ir_in = 1'b1;
      end
      S_T3: begin
        busy = 1'b1;
        if (is_unary) begin
          rout_b_en = 1'b1; alu_sel = op_sel; z_in = 1'b1;
        end else if (is_two_op || is_muldiv) begin
          rout_b_en = 1'b1; y_in = 1'b1;
        end else begin
          illegal = 1'b1; done = 1'b1;
        end
      end
      S_T4: begin
        busy = 1'b1;
        if (is_unary) begin
          zlow_out = 1'b1; rin_en = 1'b1; done = 1'b1;
        end else if (is_two_op || is_muldiv) begin
          rout_c_en = 1'b1; alu_sel = op_sel; z_in = 1'b1;
        end else begin
          done = 1'b1;
        end
      end
      S_T5: begin
        busy = 1'b1;
        if (is_muldiv) begin
          zlow_out = 1'b1; lo_in = 1'b1;
        end else if (is_two_op) begin
          zlow_out = 1'b1; rin_en = 1'b1; done = 1'b1;
        end else begin
          done = 1'b1;
        end
      end
      S_T6: begin
        busy = 1'b1; zhigh_out = 1'b1; hi_in = 1'b1; done = 1'b1;
      end
      default: ;
    endcase
  end

  // Indices at or above NUM_REGS match no bit, leaving the vector all-zero
  logic [NUM_REGS-1:0] rin_vec, rout_vec;
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi = gi + 1) begin : g_onehot
      assign rin_vec[gi]  = rin_en && (ra_idx == REG_IDX_W'(gi));
      assign rout_vec[gi] = (rout_b_en && (rb_idx == REG_IDX_W'(gi))) ||
                            (rout_c_en && (rc_idx == REG_IDX_W'(gi)));
    end
  endgenerate

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.illegal  = illegal;
  assign bus.rin      = rin_vec;
  assign bus.rout     = rout_vec;
  assign bus.alu_ctl  = alu_sel;
  assign bus.PCout    = pc_out;
  assign bus.PCin     = pc_in;
  assign bus.MARin    = mar_in;
  assign bus.Read     = mem_read;
  assign bus.MDRin    = mdr_in;
  assign bus.MDRout   = mdr_out;
  assign bus.IRin     = ir_in;
  assign bus.Yin      = y_in;
  assign bus.Zin      = z_in;
  assign bus.Zlowout  = zlow_out;
  assign bus.Zhighout = zhigh_out;
  assign bus.HIin     = hi_in;
  assign bus.LOin     = lo_in;

`ifdef ALU_SEQ_CYCLE_CNT_EN
  logic [31:0] instr_cnt_reg;
  always_ff @(posedge clock) begin
    if (!clear)    instr_cnt_reg <= '0;
    else if (done) instr_cnt_reg <= instr_cnt_reg + 32'd1;
  end
  assign bus.instr_cnt = instr_cnt_reg;
`endif
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer with a small behavioural datapath model.
// Covers ALU_SEQ_CYCLE_CNT_EN's counter when that macro is defined.
module tb_alu_instr_sequencer;
  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  alu_instr_sequencer_if bus ();

  alu_instr_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural datapath: registers, Y, Z (64-bit), HI, LO on one shared bus
  logic [31:0] regs [16];
  logic [31:0] y_reg, hi_reg, lo_reg, dbus;
  logic [63:0] z_reg;
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  logic [12:0] strb;

  assign strb = {bus.PCout, bus.PCin, bus.MARin, bus.Read, bus.MDRin, bus.MDRout, bus.IRin,
                 bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin};

  function automatic logic [63:0] alu_model(input logic [13:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] r;
    logic [63:0] dbl;
    int s;
    r = '0; dbl = {a, a}; s = int'(b[4:0]);
    case (1'b1)
      c[0]:  r = {32'h0, a + b};
      c[1]:  r = {32'h0, a - b};
      c[2]:  r = {32'h0, a & b};
      c[3]:  r = {32'h0, a | b};
      c[4]:  r = {32'h0, a >> b[4:0]};
      c[5]:  r = {32'h0, 32'($signed(a) >>> b[4:0])};
      c[6]:  r = {32'h0, a << b[4:0]};
      c[7]:  r = {32'h0, dbl[s +: 32]};
      c[8]:  r = {32'h0, dbl[(32 - s) +: 32]};
      c[9]:  r = {32'h0, -b};
      c[10]: r = {32'h0, ~b};
      c[11]: r = {32'h0, a} * {32'h0, b};
      c[12]: r = (b != 0) ? {a % b, a / b} : 64'h0;
      c[13]: r = {32'h0, b + 32'd1};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    dbus = '0;
    for (int k = 0; k < 16; k++) if (bus.rout[k]) dbus = dbus | regs[k];
    if (bus.Zlowout)  dbus = dbus | z_reg[31:0];
    if (bus.Zhighout) dbus = dbus | z_reg[63:32];
  end

  always @(posedge clock) begin
    if (poke_en) regs[poke_idx] <= poke_val;
    if (bus.Yin) y_reg <= dbus;
    if (bus.Zin) z_reg <= alu_model(bus.alu_ctl, y_reg, dbus);
    for (int k = 0; k < 16; k++) if (bus.rin[k]) regs[k] <= dbus;
    if (bus.LOin) lo_reg <= dbus;
    if (bus.HIin) hi_reg <= dbus;
  end

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clock);
    poke_en = 1'b1; poke_idx = idx[3:0]; poke_val = val;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  // Per-T-state capture of one instruction
  logic [15:0] rin_t [12];
  logic [15:0] rout_t [12];
  logic [13:0] alu_t [12];
  logic [12:0] strb_t [12];
  logic [11:0] done_mask, ill_mask;
  int ncyc, busy_cnt;

  task automatic run_instr(input logic [31:0] iv);
    for (int k = 0; k < 12; k++) begin
      rin_t[k] = '0; rout_t[k] = '0; alu_t[k] = '0; strb_t[k] = '0;
    end
    done_mask = '0; ill_mask = '0; ncyc = 0; busy_cnt = 0;
    @(negedge clock);
    bus.ir = iv; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      rin_t[k] = bus.rin; rout_t[k] = bus.rout; alu_t[k] = bus.alu_ctl; strb_t[k] = strb;
      done_mask[k] = bus.done; ill_mask[k] = bus.illegal;
      if (bus.busy) busy_cnt++;
      ncyc = k + 1;
      if (bus.done) break;
      @(negedge clock);
    end
    check("done_seen", {63'h0, bus.done}, 64'h1);
    @(negedge clock);
    check("idle_after", {63'h0, bus.busy}, 64'h0);
    $display("instr ir=%08h cycles=%0d busy=%0d done_mask=%03h illegal_mask=%03h",
             iv, ncyc, busy_cnt, done_mask, ill_mask);
  endtask

  logic [12:0] exp_fetch [3];
  logic [15:0] rin_or;
  logic [12:0] strb_or;
  logic [12:0] hist;
  int dcount;

  initial begin
    exp_fetch[0] = 13'h1410;
    exp_fetch[1] = 13'h0B08;
    exp_fetch[2] = 13'h00C0;
    bus.start = 1'b0;
    bus.ir    = '0;
    clear     = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_all", {2'b0, bus.busy, bus.done, bus.illegal, bus.rin, bus.rout, bus.alu_ctl, strb}, 64'h0);
    clear = 1'b1;

    // ROR R7,R0,R4
    poke(0, 32'hABCD1234);
    poke(4, 32'd8);
    run_instr(32'h23820000);
    check("ror_cycles", ncyc, 6);
    check("ror_busy", busy_cnt, 6);
    for (int k = 0; k < 3; k++) check($sformatf("ror_fetch_t%0d", k), strb_t[k], exp_fetch[k]);
    check("ror_incpc_t0", alu_t[0], 14'h2000);
    check("ror_t3_strb", strb_t[3], 13'h0020);
    check("ror_t3_rout", rout_t[3], 16'h0001);
    check("ror_t4_strb", strb_t[4], 13'h0010);
    check("ror_t4_rout", rout_t[4], 16'h0010);
    check("ror_t4_alu", alu_t[4], 14'h0080);
    check("ror_t5_strb", strb_t[5], 13'h0008);
    check("ror_t5_rin", rin_t[5], 16'h0080);
    check("ror_done", done_mask, 12'h020);
    check("ror_r7", regs[7], 32'h34ABCD12);

    // MUL R3,R1
    poke(3, 32'd6);
    poke(1, 32'd7);
    run_instr(32'h48188000);
    rin_or = '0;
    for (int k = 0; k < 12; k++) rin_or = rin_or | rin_t[k];
    check("mul_cycles", ncyc, 7);
    check("mul_t4_alu", alu_t[4], 14'h0800);
    check("mul_t5_strb", strb_t[5], 13'h0009);
    check("mul_t6_strb", strb_t[6], 13'h0006);
    check("mul_done", done_mask, 12'h040);
    check("mul_rin", rin_or, 16'h0);
    check("mul_lo", lo_reg, 32'd42);
    check("mul_hi", hi_reg, 32'd0);

    // NOT R2,R5 (opcode 12 -> 0x61280000)
    poke(5, 32'h0000FFFF);
    run_instr(32'h61280000);
    strb_or = '0;
    for (int k = 0; k < 12; k++) strb_or = strb_or | strb_t[k];
    check("not_cycles", ncyc, 5);
    check("not_done", done_mask, 12'h010);
    check("not_t3_alu", alu_t[3], 14'h0400);
    check("not_t4_rin", rin_t[4], 16'h0004);
    check("not_no_yin", strb_or[5], 1'b0);
    check("not_r2", regs[2], 32'hFFFF0000);

    // Illegal opcodes 13 and 18
    run_instr(32'h68000000);
    check("ill13_cycles", ncyc, 4);
    check("ill13_illegal", ill_mask, 12'h008);
    check("ill13_done", done_mask, 12'h008);
    check("ill13_t3_strb", strb_t[3], 13'h0);
    check("ill13_t3_rin", rin_t[3], 16'h0);
    run_instr(32'h91280000);
    check("ill18_illegal", ill_mask, 12'h008);
    check("ill18_r2", regs[2], 32'hFFFF0000);

    // Reset during T4 of ADD R1,R2,R3
    poke(1, 32'h11111111);
    poke(2, 32'd5);
    poke(3, 32'd9);
    @(negedge clock);
    bus.ir = 32'h00918000; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (4) @(negedge clock);
    check("abort_t4_zin", {63'h0, bus.Zin}, 64'h1);
    clear = 1'b0;
    @(negedge clock);
    check("abort_all", {2'b0, bus.busy, bus.done, bus.illegal, bus.rin, bus.rout, bus.alu_ctl, strb}, 64'h0);
    clear = 1'b1;
    check("abort_r1", regs[1], 32'h11111111);
    run_instr(32'h00918000);
    check("add_cycles", ncyc, 6);
    check("add_r1", regs[1], 32'd14);

    // start held high across two ADD R4,R2,R3
    @(negedge clock);
    bus.ir = 32'h02118000; bus.start = 1'b1;
    hist = '0; dcount = 0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clock);
      hist = {hist[11:0], bus.busy};
      if (bus.done) dcount++;
    end
    bus.start = 1'b0;
    @(negedge clock);
    $display("b2b ir=%08h busy_hist=%04h dones=%0d", bus.ir, hist, dcount);
    check("b2b_busy_hist", hist, 13'h1FBF);
    check("b2b_dones", dcount, 2);
    check("b2b_idle", {63'h0, bus.busy}, 64'h0);
    check("b2b_r4", regs[4], 32'd14);
`ifdef ALU_SEQ_CYCLE_CNT_EN
    check("instr_cnt", bus.instr_cnt, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
